oam_dma_ctrl: RTL and testbench
===============================

// Module: oam_dma_ctrl
// PURPOSE
//  Sprite DMA engine for the NES 2A03 core. Sits between the 6502 core and the memory bus.
//  A CPU write to $4014 triggers the engine:
//  - It stalls the CPU through a pause output, which gates the CPU's ce.
//  - It copies 256 bytes from page {V,8'h00} to PPU OAMDATA ($2004).
//  - It owns the bus muxing of address, data, mr and mw during the transfer.
// PARAMETERS
//  TRIGGER_ADDR  16'h4014  CPU write address that starts a transfer
//  DEST_ADDR     16'h2004  write target for every transferred byte
// PORTS
//  clk        in   1   system clock; single clock domain
//  reset      in   1   synchronous, active-high reset
//  ce         in   1   CPU-rate clock enable; all state advances only when ce=1
//  cpu_aout   in   16  CPU address
//  cpu_dout   in   8   CPU write data
//  cpu_mr     in   1   CPU read strobe
//  cpu_mw     in   1   CPU write strobe
//  mem_din    in   8   bus read data, valid in the same cycle as mem_aout
//  mem_aout   out  16  muxed bus address
//  mem_dout   out  8   muxed bus write data
//  mem_mr     out  1   muxed read strobe
//  mem_mw     out  1   muxed write strobe
//  cpu_pause  out  1   1 = CPU must hold (core ce = ce & ~cpu_pause)
//  dma_active out  1   1 while state != IDLE
// BEHAVIOUR
//  - Reset values: state=IDLE, cnt=0, page=0, data=0, parity=0.
//  - After reset: cpu_pause=0, dma_active=0, and mem_* follow cpu_* combinationally.
//  - Parity: a flop toggling on every ce cycle; it reads 0 in the first ce cycle after reset.
//  - Trigger: in IDLE, when ce & cpu_mw & cpu_aout==TRIGGER_ADDR:
//    - page <= cpu_dout and state <= HALT.
//    - The trigger write itself passes through to the bus unchanged.
//  - HALT:
//    - If cpu_mr=0 (CPU write cycle): cpu_pause=0, the CPU bus passes through, state stays HALT.
//    - If cpu_mr=1: cpu_pause=1 and the bus shows the CPU's read (dummy halt cycle).
//    - Exit from the halt cycle goes to READ if parity=1, else to ALIGN.
//  - ALIGN: one dummy cycle with cpu_pause=1 and the CPU bus shown; then READ.
//    Reads therefore always land on parity-0 cycles.
//  - READ:
//    - mem_aout={page,cnt}, mem_mr=1, mem_mw=0.
//    - data <= mem_din at the end of the ce cycle; then WRITE.
//  - WRITE:
//    - mem_aout=DEST_ADDR, mem_dout=data, mem_mw=1, mem_mr=0.
//    - cnt <= cnt+1. If cnt==8'hFF: state <= IDLE and cnt wraps to 0; else READ.
//  - cpu_pause is 1 in HALT (read cycle), ALIGN, READ and WRITE.
//    It drops in the ce cycle after the final WRITE.
//  - Total paused cycles: 513 (no align) or 514 (align).
//  - Address arithmetic: the low byte is cnt only; the page never increments
//    (page $FF ends at $FFFF, with no carry).
//  - Triggers are ignored while state != IDLE. The CPU is paused in that time, so it cannot issue one.
//  - ce=0: every flop holds its value; the mux outputs still reflect the current state.
//  - Reset mid-transfer: the next cycle is IDLE with cpu_pause=0; the remaining bytes are abandoned.
// CONFIGURATION
//  OAM_DMA_ALIGN_EN
//  - Defined: HALT/ALIGN parity handling as described above.
//  - Undefined: the ALIGN state is not built; HALT always goes to READ; fixed 513 paused cycles.
//    The parity flop is removed.
// STRUCTURE
//  - Shared include nes_defs.vh holds:
//    - the constants REG_OAMDMA=16'h4014 and REG_OAMDATA=16'h2004, used as parameter defaults;
//    - the DMA state encoding (IDLE, HALT, ALIGN, READ, WRITE; 3 bits).
//  - Sub-module oam_dma_bus_mux: combinational selection of CPU or DMA bus outputs
//    from state, page, cnt and data.
//  - The FSM, counter and latches stay in oam_dma_ctrl.
// TESTING
//  1. IDLE, write $4014=8'h02 on a parity-1 cycle, CPU reads next:
//     - reads $0200..$02FF, writes $2004 with matching data;
//     - 514 paused cycles with ALIGN.
//  2. Same trigger with parity flipped (one extra prior cycle) -> 513 paused cycles, no ALIGN.
//  3. Trigger followed by two CPU write cycles (JSR-style push):
//     - both writes reach the bus with cpu_pause=0;
//     - pause asserts on the first read.
//  4. reset asserted at byte 100 (cnt=8'h64):
//     - next cycle: cpu_pause=0 and dma_active=0, mem_* equal cpu_*;
//     - no further $2004 writes.
//  5. Random ce=0 gaps (about 30%) during a page-$07 transfer -> identical address/data sequence,
//     and 513/514 counted in ce=1 cycles.
//  6. Page 8'hFF with mem_din=address low byte -> last read $FFFF, last write data 8'hFF,
//     then IDLE with cnt=0.

Source files
------------

// File: rtl/oam_dma_ctrl_pkg.sv
// Shared constants for the 2A03 sprite DMA engine: register addresses and FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package oam_dma_ctrl_pkg;

  // CPU-visible register addresses, used as parameter defaults.
  localparam logic [15:0] REG_OAMDMA  = 16'h4014;
  localparam logic [15:0] REG_OAMDATA = 16'h2004;

  // DMA state encoding (3 bits).
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HALT  = 3'd1;
  localparam logic [2:0] ST_ALIGN = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;

  // Source address of a DMA byte: the page never carries, the low byte is the count.
  function automatic logic [15:0] dmaAddr(input logic [7:0] page, input logic [7:0] cnt);
    return {page, cnt};
  endfunction

endpackage

// File: rtl/oam_dma_bus_mux.sv
// Selects CPU pass-through or DMA-driven bus outputs from the current DMA state.
// Latency: purely combinational, zero cycles.
// Backpressure: raises cpu_pause whenever the DMA owns the bus (or on the halt read cycle).
module oam_dma_bus_mux
  import oam_dma_ctrl_pkg::*;
#(
  parameter logic [15:0] DEST_ADDR = REG_OAMDATA
) (
  input  logic [2:0]  state,
  input  logic [7:0]  page,
  input  logic [7:0]  cnt,
  input  logic [7:0]  data,
  input  logic [15:0] cpu_aout,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mr,
  input  logic        cpu_mw,
  output logic [15:0] mem_aout,
  output logic [7:0]  mem_dout,
  output logic        mem_mr,
  output logic        mem_mw,
  output logic        cpu_pause,
  output logic        dma_active
);

  // Default to the CPU bus; READ/WRITE take it over, HALT/ALIGN only stall the CPU.
  always_comb begin
    mem_aout  = cpu_aout;
    mem_dout  = cpu_dout;
    mem_mr    = cpu_mr;
    mem_mw    = cpu_mw;
    cpu_pause = 1'b0;
    case (state)
      ST_HALT: begin
        // CPU write cycles cannot be stalled; only a read cycle is held.
        cpu_pause = cpu_mr;
      end
      ST_ALIGN: begin
        cpu_pause = 1'b1;
      end
      ST_READ: begin
        mem_aout  = dmaAddr(page, cnt);
        mem_dout  = data;
        mem_mr    = 1'b1;
        mem_mw    = 1'b0;
        cpu_pause = 1'b1;
      end
      ST_WRITE: begin
        mem_aout  = DEST_ADDR;
        mem_dout  = data;
        mem_mr    = 1'b0;
        mem_mw    = 1'b1;
        cpu_pause = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign dma_active = (state != ST_IDLE);

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA engine: a CPU write to TRIGGER_ADDR copies page {V,00}..{V,FF} to DEST_ADDR.
// Latency: 513 paused ce cycles, or 514 when OAM_DMA_ALIGN_EN inserts an align cycle.
// Backpressure: stalls the CPU through cpu_pause; all state advances only on ce.
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = REG_OAMDMA,
  parameter logic [15:0] DEST_ADDR    = REG_OAMDATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] cpu_aout,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mr,
  input  logic        cpu_mw,
  input  logic [7:0]  mem_din,
  output logic [15:0] mem_aout,
  output logic [7:0]  mem_dout,
  output logic        mem_mr,
  output logic        mem_mw,
  output logic        cpu_pause,
  output logic        dma_active
);

  logic [2:0] state;
  logic [7:0] cnt;
  logic [7:0] page;
  logic [7:0] data;

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  // Free-running ce-cycle phase so that DMA reads always land on even cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity <= 1'b0;
    end else if (ce) begin
      parity <= ~parity;
    end
  end
`endif

  // Transfer FSM: trigger capture, halt/align, then 256 read/write pairs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 8'h00;
      page  <= 8'h00;
      data  <= 8'h00;
    end else if (ce) begin
      case (state)
        ST_IDLE: begin
          if (cpu_mw && (cpu_aout == TRIGGER_ADDR)) begin
            page  <= cpu_dout;
            state <= ST_HALT;
          end
        end
        ST_HALT: begin
          // Wait out CPU write cycles; leave on the first read cycle.
          if (cpu_mr) begin
`ifdef OAM_DMA_ALIGN_EN
            state <= parity ? ST_READ : ST_ALIGN;
`else
            state <= ST_READ;
`endif
          end
        end
`ifdef OAM_DMA_ALIGN_EN
        ST_ALIGN: begin
          state <= ST_READ;
        end
`endif
        ST_READ: begin
          data  <= mem_din;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          // cnt wraps to 0 after the last byte, ready for the next transfer.
          cnt   <= cnt + 8'd1;
          state <= (cnt == 8'hFF) ? ST_IDLE : ST_READ;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  oam_dma_bus_mux #(
    .DEST_ADDR (DEST_ADDR)
  ) uBusMux (
    .state      (state),
    .page       (page),
    .cnt        (cnt),
    .data       (data),
    .cpu_aout   (cpu_aout),
    .cpu_dout   (cpu_dout),
    .cpu_mr     (cpu_mr),
    .cpu_mw     (cpu_mw),
    .mem_aout   (mem_aout),
    .mem_dout   (mem_dout),
    .mem_mr     (mem_mr),
    .mem_mw     (mem_mw),
    .cpu_pause  (cpu_pause),
    .dma_active (dma_active)
  );

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: directed transfers with random data, CPU traffic and ce gaps,
// checked beat-by-beat against an expected bus sequence built from the transfer rules.
// Honours OAM_DMA_ALIGN_EN when deciding whether an align cycle is expected.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic [15:0] cpu_aout;
  logic [7:0]  cpu_dout;
  logic        cpu_mr;
  logic        cpu_mw;
  logic [7:0]  mem_din;
  logic [15:0] mem_aout;
  logic [7:0]  mem_dout;
  logic        mem_mr;
  logic        mem_mw;
  logic        cpu_pause;
  logic        dma_active;

  logic [7:0]  memArr [0:65535];

  int total = 0;
  int bad = 0;
  int ceCount = 0;
  int pauseCnt = 0;

  // One expected bus beat: either CPU pass-through or a DMA-driven access.
  typedef struct packed {
    logic        pass;
    logic        pause;
    logic        active;
    logic [15:0] a;
    logic [7:0]  d;
    logic        mr;
    logic        mw;
    logic        dCare;
  } beat_t;

  oam_dma_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .cpu_aout   (cpu_aout),
    .cpu_dout   (cpu_dout),
    .cpu_mr     (cpu_mr),
    .cpu_mw     (cpu_mw),
    .mem_din    (mem_din),
    .mem_aout   (mem_aout),
    .mem_dout   (mem_dout),
    .mem_mr     (mem_mr),
    .mem_mw     (mem_mw),
    .cpu_pause  (cpu_pause),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  // Memory answers in the same cycle as the address.
  assign mem_din = memArr[mem_aout];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic beat_t passBeat(input logic pause, input logic active);
    beat_t b;
    b = '0;
    b.pass = 1'b1;
    b.pause = pause;
    b.active = active;
    return b;
  endfunction

  function automatic beat_t dmaBeat(input logic [15:0] a, input logic [7:0] d,
                                    input logic mr, input logic mw, input logic dCare);
    beat_t b;
    b = '0;
    b.pause = 1'b1;
    b.active = 1'b1;
    b.a = a;
    b.d = d;
    b.mr = mr;
    b.mw = mw;
    b.dCare = dCare;
    return b;
  endfunction

  task automatic checkBeat(input beat_t b, input string tag);
    logic [31:0] got;
    logic [31:0] exp;
    logic [7:0]  dm;
    dm = (b.pass || b.dCare) ? 8'hFF : 8'h00;
    got = {4'b0, cpu_pause, dma_active, mem_aout, mem_dout & dm, mem_mr, mem_mw};
    if (b.pass)
      exp = {4'b0, b.pause, b.active, cpu_aout, cpu_dout, cpu_mr, cpu_mw};
    else
      exp = {4'b0, b.pause, b.active, b.a, b.d & dm, b.mr, b.mw};
    chk(tag, got, exp);
  endtask

  // Holds one expected beat until a ce=1 cycle consumes it; ce=0 gaps must show the same beat.
  task automatic runBeat(input beat_t b, input int gapPct, input string tag);
    bit done;
    int gaps;
    done = 1'b0;
    gaps = 0;
    while (!done) begin
      if (gaps < 16 && int'($urandom_range(99)) < gapPct) ce = 1'b0;
      else ce = 1'b1;
      @(negedge clk);
      checkBeat(b, tag);
      if (ce && cpu_pause) pauseCnt++;
      @(posedge clk);
      #1;
      if (ce) begin
        ceCount++;
        done = 1'b1;
      end else begin
        gaps++;
      end
    end
  endtask

  task automatic setCpu(input logic [15:0] a, input logic [7:0] d, input logic mr, input logic mw);
    cpu_aout = a;
    cpu_dout = d;
    cpu_mr = mr;
    cpu_mw = mw;
  endtask

  task automatic cpuIdleRead();
    setCpu({1'b1, 15'($urandom)}, 8'($urandom), 1'b1, 1'b0);
  endtask

  // Full transfer model: trigger, optional pushes, halt read, optional align,
  // 256 read/write pairs, then the bus returns to the CPU.
  task automatic doXfer(input logic [7:0] page, input int nWrites, input int gapPct,
                        input int resetAt, input string name);
    bit al;
    pauseCnt = 0;
    setCpu(16'h4014, page, 1'b0, 1'b1);
    runBeat(passBeat(1'b0, 1'b0), gapPct, {name, " trigger"});
    for (int k = 0; k < nWrites; k++) begin
      setCpu(16'h01FF - 16'(k), 8'($urandom), 1'b0, 1'b1);
      runBeat(passBeat(1'b0, 1'b1), gapPct, $sformatf("%s push%0d", name, k));
    end
    cpuIdleRead();
`ifdef OAM_DMA_ALIGN_EN
    al = (ceCount % 2) == 0;
`else
    al = 1'b0;
`endif
    runBeat(passBeat(1'b1, 1'b1), gapPct, {name, " halt"});
    if (al) runBeat(passBeat(1'b1, 1'b1), gapPct, {name, " align"});
    for (int i = 0; i < 256; i++) begin
      if (i == resetAt) begin
        reset = 1'b1;
        runBeat(dmaBeat({page, 8'(i)}, 8'h00, 1'b1, 1'b0, 1'b0), 0, {name, " rd at reset"});
        reset = 1'b0;
        ceCount = 0;
        for (int j = 0; j < 8; j++) begin
          cpuIdleRead();
          runBeat(passBeat(1'b0, 1'b0), gapPct, $sformatf("%s after reset%0d", name, j));
        end
        return;
      end
      runBeat(dmaBeat({page, 8'(i)}, 8'h00, 1'b1, 1'b0, 1'b0), gapPct,
              $sformatf("%s rd%0d", name, i));
      runBeat(dmaBeat(16'h2004, memArr[{page, 8'(i)}], 1'b0, 1'b1, 1'b1), gapPct,
              $sformatf("%s wr%0d", name, i));
    end
    chk({name, " paused cycles"}, 32'(pauseCnt), al ? 32'd514 : 32'd513);
    cpuIdleRead();
    runBeat(passBeat(1'b0, 1'b0), gapPct, {name, " done"});
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) memArr[i] = 8'($urandom);
    reset = 1'b1;
    ce = 1'b1;
    setCpu(16'h0000, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    ceCount = 0;

    // Idle after reset: pure pass-through, no pause.
    for (int i = 0; i < 4; i++) begin
      setCpu({1'b1, 15'($urandom)}, 8'($urandom), 1'($urandom), 1'($urandom));
      runBeat(passBeat(1'b0, 1'b0), 0, $sformatf("reset idle%0d", i));
    end

    // A trigger write while ce=0 must not start a transfer.
    setCpu(16'h4014, 8'h33, 1'b0, 1'b1);
    ce = 1'b0;
    @(negedge clk);
    checkBeat(passBeat(1'b0, 1'b0), "trigger ce0");
    @(posedge clk);
    #1;
    cpuIdleRead();
    runBeat(passBeat(1'b0, 1'b0), 0, "after trigger ce0");

    // Trigger on an odd ce cycle, then on an even one.
    if (ceCount % 2 == 0) begin
      cpuIdleRead();
      runBeat(passBeat(1'b0, 1'b0), 0, "pad t1");
    end
    doXfer(8'h02, 0, 0, -1, "t1");
    if (ceCount % 2 == 1) begin
      cpuIdleRead();
      runBeat(passBeat(1'b0, 1'b0), 0, "pad t2");
    end
    doXfer(8'h02, 0, 0, -1, "t2");

    // Pushes during HALT pass through unpaused.
    doXfer(8'h03, 2, 0, -1, "t3");

    // Reset mid-transfer abandons the rest.
    doXfer(8'h04, 0, 0, 100, "t4");

    // Top page, data equals address low byte; the following transfer starts at offset 0.
    for (int i = 0; i < 256; i++) memArr[{8'hFF, 8'(i)}] = 8'(i);
    doXfer(8'hFF, 0, 0, -1, "t6");
    doXfer(8'h07, 0, 30, -1, "t5");

    // Random page, random pushes, light ce gaps.
    doXfer(8'($urandom), int'($urandom_range(2)), 20, -1, "rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
